memory_arbiter: RTL and testbench

//  Sits directly downstream of the core's two memory ports (fetch port, memory-stage data port).

---
 rtl/memory_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Merges the core's fetch port and memory-stage data port onto one shared
// memory bus with at most one transaction in flight. The data port wins
// arbitration by default; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken while fetch was waiting.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   inst_start        : fetch request (level)
//   inst_ready        : fetch request accepted this cycle (with inst_start)
//   i_addr            : fetch byte address
//   inst, inst_valid  : fetched word and its one-cycle valid pulse
//   d_cmd             : 0=NONE 1=READ 2=WRITE, 3..7 treated as NONE
//   d_cmd_ready       : data command accepted this cycle
//   d_addr, wdata,
//   wmask             : data address, store data, per-bit write mask
//   rdata, rdata_valid: load data and its one-cycle valid pulse
//   bus_valid/ready   : bus request handshake
//   bus_write         : 1=write 0=read
//   bus_addr/wdata/
//   wmask             : request fields, stable while bus_valid is high
//   bus_rdata(_valid) : read response from the bus (single-cycle valid)
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        inst_start,
  output logic        inst_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  // data port
  input  logic [2:0]  d_cmd,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wmask,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  // shared memory bus
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] bus_wmask,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdata_valid
);

  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;

  // Wide enough to hold STARVE_LIMIT itself, so the >= test can be reached.
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             owner_reg;
  logic [CNT_W-1:0] starve_cnt_reg;

  logic             bus_write_reg;
  logic [31:0]      bus_addr_reg;
  logic [31:0]      bus_wdata_reg;
  logic [31:0]      bus_wmask_reg;

  logic [31:0]      inst_reg;
  logic [31:0]      rdata_reg;
  logic             inst_valid_reg;
  logic             rdata_valid_reg;

  logic             data_pending;
  logic             forced;
  logic             grant_data;
  logic             grant_fetch;
  logic             complete;

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  assign data_pending = (d_cmd == CMD_READ) || (d_cmd == CMD_WRITE);

  generate
    if (STARVE_LIMIT == 0) begin : g_no_force
      assign forced = 1'b0;
    end else begin : g_force
      assign forced = inst_start && (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));
    end
  endgenerate

  assign grant_data  = !rst && (state_reg == IDLE) && data_pending && !forced;
  assign grant_fetch = !rst && (state_reg == IDLE) && !grant_data && inst_start;

  assign d_cmd_ready = grant_data;
  assign inst_ready  = grant_fetch;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_data || grant_fetch) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_ready) begin
          if (bus_write_reg) begin
            // Writes are posted: no response is expected.
            state_next = IDLE;
          end else if (bus_rdata_valid) begin
            // Zero-latency response arriving with the accept.
            state_next = IDLE;
            complete   = 1'b1;
          end else begin
            state_next = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (bus_rdata_valid) begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, request latch, starvation counter, response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      owner_reg       <= OWNER_FETCH;
      starve_cnt_reg  <= '0;
      bus_write_reg   <= 1'b0;
      bus_addr_reg    <= '0;
      bus_wdata_reg   <= '0;
      bus_wmask_reg   <= '0;
      inst_reg        <= '0;
      rdata_reg       <= '0;
      inst_valid_reg  <= 1'b0;
      rdata_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Request fields are captured at grant and left untouched until the
      // next grant, so they stay stable for the whole ISSUE phase.
      if (grant_data) begin
        owner_reg     <= OWNER_DATA;
        bus_write_reg <= (d_cmd == CMD_WRITE);
        bus_addr_reg  <= d_addr;
        bus_wdata_reg <= wdata;
        bus_wmask_reg <= wmask;
      end else if (grant_fetch) begin
        owner_reg     <= OWNER_FETCH;
        bus_write_reg <= 1'b0;
        bus_addr_reg  <= i_addr;
        bus_wdata_reg <= '0;
        bus_wmask_reg <= '0;
      end

      // Counts data grants that bypassed a waiting fetch; any IDLE cycle
      // without a fetch request means fetch is no longer being starved.
      if (state_reg == IDLE) begin
        if (grant_data && inst_start) begin
          if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end
        end else if (grant_fetch || !inst_start) begin
          starve_cnt_reg <= '0;
        end
      end

      inst_valid_reg  <= complete && (owner_reg == OWNER_FETCH);
      rdata_valid_reg <= complete && (owner_reg == OWNER_DATA);

      if (complete && (owner_reg == OWNER_FETCH)) begin
        inst_reg <= bus_rdata;
      end
      if (complete && (owner_reg == OWNER_DATA)) begin
        rdata_reg <= bus_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_valid   = (state_reg == ISSUE);
  assign bus_write   = bus_write_reg;
  assign bus_addr    = bus_addr_reg;
  assign bus_wdata   = bus_wdata_reg;
  assign bus_wmask   = bus_wmask_reg;

  assign inst        = inst_reg;
  assign inst_valid  = inst_valid_reg;
  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Drives directed scenarios followed by randomized traffic. A transaction-level
// reference model (one outstanding request, starvation count, expected pulses)
// predicts every cycle's readies, bus request and responses.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_start;
  logic        inst_ready;
  logic [31:0] i_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic [2:0]  d_cmd;
  logic        d_cmd_ready;
  logic [31:0] d_addr;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_wmask;
  logic [31:0] bus_rdata;
  logic        bus_rdata_valid;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_start      (inst_start),
    .inst_ready      (inst_ready),
    .i_addr          (i_addr),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .d_cmd           (d_cmd),
    .d_cmd_ready     (d_cmd_ready),
    .d_addr          (d_addr),
    .wdata           (wdata),
    .wmask           (wmask),
    .rdata           (rdata),
    .rdata_valid     (rdata_valid),
    .bus_valid       (bus_valid),
    .bus_ready       (bus_ready),
    .bus_write       (bus_write),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_wmask       (bus_wmask),
    .bus_rdata       (bus_rdata),
    .bus_rdata_valid (bus_rdata_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_busy, m_acc, m_pi, m_pd;
  bit          m_write, m_owner_data;
  logic [31:0] m_addr, m_wdata, m_wmask, m_inst, m_rdata;
  int          m_starve;
  bit          g_i, g_d;
  bit          dut_log[$];

  // Bus responder knobs
  int          ready_pct, same_pct, resp_pct, stray_pct;
  bit          fix_rdata;
  logic [31:0] fix_val;
  bit          rd_out;
  bit          auto_drop, hold_i, hold_d;

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic drive_bus();
    bus_ready       = pct(ready_pct);
    bus_rdata       = fix_rdata ? fix_val : $urandom;
    bus_rdata_valid = 1'b0;
    if (bus_valid) begin
      if (bus_ready && !bus_write) bus_rdata_valid = pct(same_pct);
    end else if (rd_out) begin
      bus_rdata_valid = pct(resp_pct);
    end else begin
      bus_rdata_valid = pct(stray_pct);
    end
    if (bus_valid && bus_ready && !bus_write && !bus_rdata_valid) rd_out = 1'b1;
    else if (!bus_valid && bus_rdata_valid) rd_out = 1'b0;
  endtask

  task automatic deliver();
    m_busy = 1'b0;
    m_acc  = 1'b0;
    if (m_owner_data) begin
      m_rdata = bus_rdata;
      m_pd    = 1'b1;
    end else begin
      m_inst = bus_rdata;
      m_pi   = 1'b1;
    end
  endtask

  task automatic check_and_advance();
    bit dp, forced, exp_dr, exp_ir;
    dp     = (d_cmd == 3'd1) || (d_cmd == 3'd2);
    forced = (LIMIT != 0) && (m_starve >= LIMIT) && inst_start;
    exp_dr = !rst && !m_busy && dp && !forced;
    exp_ir = !rst && !m_busy && !exp_dr && inst_start;

    check_val("d_cmd_ready", d_cmd_ready, exp_dr);
    check_val("inst_ready", inst_ready, exp_ir);
    check_val("bus_valid", bus_valid, m_busy && !m_acc);
    if (m_busy && !m_acc) begin
      check_val("bus_addr", bus_addr, m_addr);
      check_val("bus_write", bus_write, m_write);
      if (m_write) begin
        check_val("bus_wdata", bus_wdata, m_wdata);
        check_val("bus_wmask", bus_wmask, m_wmask);
      end
    end
    check_val("inst_valid", inst_valid, m_pi);
    check_val("rdata_valid", rdata_valid, m_pd);
    check_val("inst", inst, m_inst);
    check_val("rdata", rdata, m_rdata);

    if (d_cmd_ready && dp) dut_log.push_back(1'b1);
    if (inst_ready && inst_start) dut_log.push_back(1'b0);

    g_i  = 1'b0;
    g_d  = 1'b0;
    m_pi = 1'b0;
    m_pd = 1'b0;
    if (rst) begin
      m_busy   = 1'b0;
      m_acc    = 1'b0;
      m_starve = 0;
      m_inst   = '0;
      m_rdata  = '0;
    end else if (m_busy) begin
      if (!m_acc) begin
        if (bus_ready) begin
          if (m_write) m_busy = 1'b0;
          else if (bus_rdata_valid) deliver();
          else m_acc = 1'b1;
        end
      end else if (bus_rdata_valid) begin
        deliver();
      end
    end else begin
      if (exp_dr && inst_start) m_starve++;
      else if (exp_ir || !inst_start) m_starve = 0;
      if (exp_dr) begin
        g_d = 1'b1; m_busy = 1'b1; m_acc = 1'b0; m_owner_data = 1'b1;
        m_write = (d_cmd == 3'd2); m_addr = d_addr; m_wdata = wdata; m_wmask = wmask;
      end else if (exp_ir) begin
        g_i = 1'b1; m_busy = 1'b1; m_acc = 1'b0; m_owner_data = 1'b0;
        m_write = 1'b0; m_addr = i_addr;
      end
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    drive_bus();
    #1;
    check_and_advance();
    @(negedge clk);
    if (auto_drop) begin
      if (g_d && !hold_d) d_cmd = 3'd0;
      if (g_i && !hold_i) inst_start = 1'b0;
    end
  endtask

  task automatic set_bus(input int r, input int s, input int p, input int st);
    ready_pct = r; same_pct = s; resp_pct = p; stray_pct = st;
  endtask

  int sz;

  initial begin
    rst = 1'b1; inst_start = 1'b0; i_addr = '0; d_cmd = 3'd0; d_addr = '0;
    wdata = '0; wmask = '0; bus_ready = 1'b0; bus_rdata = '0; bus_rdata_valid = 1'b0;
    m_busy = 0; m_acc = 0; m_pi = 0; m_pd = 0; m_write = 0; m_owner_data = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_inst = '0; m_rdata = '0; m_starve = 0;
    rd_out = 0; fix_rdata = 0; fix_val = '0; auto_drop = 1; hold_i = 0; hold_d = 0;
    set_bus(100, 0, 100, 0);

    @(negedge clk);
    step();
    check_val("rst_bus_addr", bus_addr, 32'h0);
    check_val("rst_inst", inst, 32'h0);
    rst = 1'b0;

    // 1: simple fetch with a one-cycle bus response
    fix_rdata = 1; fix_val = 32'hDEADBEEF;
    inst_start = 1; i_addr = 32'h100;
    repeat (5) step();
    check_val("t1_inst", inst, 32'hDEADBEEF);
    fix_rdata = 0;

    // 2: simultaneous requests, data first then fetch
    sz = dut_log.size();
    inst_start = 1; i_addr = 32'h300; d_cmd = 3'd1; d_addr = 32'h2000;
    repeat (10) step();
    check_val("t2_first_data", (dut_log.size() > sz) ? dut_log[sz] : 1'b0, 1'b1);
    check_val("t2_then_fetch", (dut_log.size() > sz + 1) ? dut_log[sz+1] : 1'b1, 1'b0);

    // 3: stalled write keeps its fields stable, no response pulse
    set_bus(0, 0, 100, 0);
    d_cmd = 3'd2; d_addr = 32'h40; wdata = 32'h12345678; wmask = 32'h0000FFFF;
    step();
    for (int k = 0; k < 4; k++) begin
      ready_pct = (k == 3) ? 100 : 0;
      check_val("t3_bus_valid", bus_valid, 1'b1);
      check_val("t3_addr", bus_addr, 32'h40);
      check_val("t3_wdata", bus_wdata, 32'h12345678);
      check_val("t3_wmask", bus_wmask, 32'h0000FFFF);
      step();
    end
    check_val("t3_idle", bus_valid, 1'b0);
    step();

    // 4: continuous data reads starve fetch until forced
    set_bus(100, 100, 100, 0);
    sz = dut_log.size();
    hold_d = 1; hold_i = 1;
    d_cmd = 3'd1; d_addr = 32'h80; inst_start = 1; i_addr = 32'h500;
    repeat (30) step();
    hold_d = 0; hold_i = 0; d_cmd = 3'd0; inst_start = 0;
    repeat (4) step();
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("t4_grant%0d", k),
                (dut_log.size() > sz + k) ? dut_log[sz+k] : 1'bx,
                (k == 4 || k == 9) ? 1'b0 : 1'b1);
    end

    // 5: reset while waiting for read data, late response ignored
    set_bus(100, 0, 0, 0);
    inst_start = 1; i_addr = 32'h600;
    repeat (3) step();
    rst = 1;
    step();
    rst = 0; inst_start = 1; resp_pct = 100;
    #1;
    check_val("t5_inst_ready", inst_ready, 1'b1);
    check_val("t5_no_pulse", inst_valid, 1'b0);
    step();
    repeat (6) step();

    // 6: same-cycle accept and response, back-to-back grant in pulse cycle
    set_bus(100, 100, 100, 0);
    d_cmd = 3'd1; d_addr = 32'h900; inst_start = 1; i_addr = 32'hA00;
    step();
    step();
    #1;
    check_val("t6_pulse", rdata_valid, 1'b1);
    check_val("t6_b2b_grant", inst_ready, 1'b1);
    repeat (6) step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        set_bus($urandom_range(100, 20), $urandom_range(50, 0),
                $urandom_range(100, 20), $urandom_range(20, 0));
      end
      rst = pct(1);
      if (!inst_start) begin
        inst_start = pct(35);
        i_addr = $urandom;
      end
      if (!(d_cmd == 3'd1 || d_cmd == 3'd2)) begin
        d_cmd  = pct(50) ? 3'($urandom_range(7, 0)) : 3'd0;
        d_addr = $urandom; wdata = $urandom; wmask = $urandom;
      end
      step();
    end

    rst = 0; inst_start = 0; d_cmd = 3'd0;
    set_bus(100, 0, 100, 0);
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
